skolem_sweep_ctrl: RTL and testbench

Sequential controller that exhaustively exercises one combinational Skolem-function netlist (N_IN inputs, one output bit) by enumerating every input vector 0 .. 2^N_IN−1. It compares each Skolem output against an oracle bit supplied alongside it and reports the pass/fail verdict and the mismatch count. It sits between the bench/top-level and one Skolem netlist instance, sequencing it so the netlist needs no clock of its own.

---
 rtl/skolem_sweep_pkg.sv | 18 +
 rtl/sweep_tag_pipe.sv | 42 ++++
 rtl/skolem_sweep_ctrl.sv | 130 +++++++++++++
 tb/tb_skolem_sweep_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/skolem_sweep_pkg.sv
// Shared types and constants for the Skolem-netlist sweep controller.
package skolem_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_e;

  localparam int unsigned LAT_MAX = 4;

  // Number of input vectors in an exhaustive sweep of n_in inputs.
  function automatic int unsigned vec_count(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/sweep_tag_pipe.sv
// LAT-deep tag shift register (valid + vector) aligning issued vectors with
// the Skolem netlist output; synchronous flush, combinational empty flag.
module sweep_tag_pipe
  import skolem_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 8,
  parameter int unsigned LAT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push_vld,
  input  logic [N_IN-1:0] push_vec,
  output logic            out_vld,
  output logic [N_IN-1:0] out_vec,
  output logic            empty_c
);

  localparam int unsigned DEPTH = (LAT > LAT_MAX) ? LAT_MAX : ((LAT < 1) ? 1 : LAT);
  localparam int unsigned VW    = DEPTH * N_IN;

  // Newest tag enters at the low slot and walks upward one slot per cycle.
  logic [DEPTH-1:0] vld;
  logic [VW-1:0]    vec;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld <= '0;
    end else begin
      vld <= DEPTH'({vld, push_vld});
    end
  end

  always_ff @(posedge clk) begin
    vec <= VW'({vec, push_vec});
  end

  assign out_vld = vld[DEPTH-1];
  assign out_vec = vec[VW-1 -: N_IN];
  assign empty_c = ~|vld;

endmodule

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep controller for one combinational Skolem netlist: issues
// every input vector, compares against the oracle and reports the verdict.
// Optional first-mismatch capture is enabled by defining SKSWEEP_FIRSTFAIL_EN.
module skolem_sweep_ctrl
  import skolem_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 8,
  parameter int unsigned LAT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  output logic [N_IN-1:0] sk_in,
  input  logic            sk_out,
  input  logic            exp_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld
);

  localparam int unsigned CNT_W    = N_IN + 1;
  localparam int unsigned VEC_LAST = vec_count(N_IN) - 1;

  sweep_state_e    state;
  logic            issue_c;
  logic            mismatch_c;
  logic            tag_vld;
  logic [N_IN-1:0] tag_vec;
  logic            pipe_empty_c;

  assign issue_c    = (state == RUN) && !hold && !abort;
  assign mismatch_c = tag_vld && (sk_out != exp_out);

  sweep_tag_pipe #(
    .N_IN (N_IN),
    .LAT  (LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .push_vld (issue_c),
    .push_vec (sk_in),
    .out_vld  (tag_vld),
    .out_vec  (tag_vec),
    .empty_c  (pipe_empty_c)
  );

  // Sweep FSM, vector counter and saturating mismatch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sk_in    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_cnt <= '0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mismatch_c && (fail_cnt != '1)) begin
        fail_cnt <= fail_cnt + CNT_W'(1);
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            sk_in    <= '0;
            pass     <= 1'b0;
            fail_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (!hold) begin
            if (sk_in == N_IN'(VEC_LAST)) begin
              state <= DRAIN;
            end else begin
              sk_in <= sk_in + N_IN'(1);
            end
          end
        end
        DRAIN: begin
          // Empty only after the last tag has been compared, so fail_cnt is final.
          if (pipe_empty_c) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_cnt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SKSWEEP_FIRSTFAIL_EN
  // Capture the first counted mismatch of a sweep; survives abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else if (!abort) begin
      if (((state == IDLE) || (state == DONE)) && start) begin
        first_fail     <= '0;
        first_fail_vld <= 1'b0;
      end else if (mismatch_c && !first_fail_vld) begin
        first_fail     <= tag_vec;
        first_fail_vld <= 1'b1;
      end
    end
  end
`else
  logic unused_tag_c;
  assign unused_tag_c   = ^tag_vec;
  assign first_fail     = '0;
  assign first_fail_vld = 1'b0;
`endif

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Bench for skolem_sweep_ctrl: two instances (LAT=1, LAT=3) driven by
// randomized sweeps and checked against a vector-level reference model.
module tb_skolem_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] start_v, abort_v, hold_v;
  logic [1:0] sk_out_v, exp_out_v;
  logic [7:0] sk_in_w [2];
  logic [1:0] busy_w, done_w, pass_w, ffv_w;
  logic [8:0] fail_cnt_w [2];
  logic [7:0] first_fail_w [2];

  bit [255:0] flip_tab;
  logic [7:0] dl0;
  logic [7:0] dl1 [3];

  int n_chk  = 0;
  int n_pass = 0;

  skolem_sweep_ctrl #(.N_IN(8), .LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .hold(hold_v[0]),
    .sk_in(sk_in_w[0]), .sk_out(sk_out_v[0]), .exp_out(exp_out_v[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail_cnt(fail_cnt_w[0]),
    .first_fail(first_fail_w[0]), .first_fail_vld(ffv_w[0])
  );

  skolem_sweep_ctrl #(.N_IN(8), .LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .hold(hold_v[1]),
    .sk_in(sk_in_w[1]), .sk_out(sk_out_v[1]), .exp_out(exp_out_v[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail_cnt(fail_cnt_w[1]),
    .first_fail(first_fail_w[1]), .first_fail_vld(ffv_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic skolem_f(input logic [7:0] v);
    return (^(v & 8'h5A)) ^ (v[7] & v[1]);
  endfunction

  // Netlist model: output follows sk_in after LAT register stages.
  always @(posedge clk) begin
    dl0    <= sk_in_w[0];
    dl1[0] <= sk_in_w[1];
    dl1[1] <= dl1[0];
    dl1[2] <= dl1[1];
  end

  assign sk_out_v[0]  = skolem_f(dl0);
  assign exp_out_v[0] = skolem_f(dl0) ^ flip_tab[dl0];
  assign sk_out_v[1]  = skolem_f(dl1[2]);
  assign exp_out_v[1] = skolem_f(dl1[2]) ^ flip_tab[dl1[2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_flips(input int n);
    flip_tab = '0;
    repeat (n) flip_tab[8'($urandom_range(0, 255))] = 1'b1;
  endtask

  task automatic check_reset(input int idx, input string tag);
    check({tag, " busy"},     32'(busy_w[idx]),       32'd0);
    check({tag, " done"},     32'(done_w[idx]),       32'd0);
    check({tag, " pass"},     32'(pass_w[idx]),       32'd0);
    check({tag, " fail_cnt"}, 32'(fail_cnt_w[idx]),   32'd0);
    check({tag, " sk_in"},    32'(sk_in_w[idx]),      32'd0);
    check({tag, " ff"},       32'(first_fail_w[idx]), 32'd0);
    check({tag, " ffv"},      32'(ffv_w[idx]),        32'd0);
  endtask

  // One full sweep; expectations come from the flip table and hold count.
  task automatic sweep(input int idx, input bit do_start, input int hold_off,
                       input int hold_len, input bit mid_start, input bit restart,
                       input string tag);
    int cyc, seq_err, distinct, exp_fail, exp_first, lat;
    logic [7:0] prev;
    lat = (idx == 1) ? 3 : 1;
    exp_fail = 0;
    exp_first = 0;
    seq_err = 0;
    distinct = 0;
    for (int v = 255; v >= 0; v--) begin
      if (flip_tab[v]) begin
        exp_fail++;
        exp_first = v;
      end
    end
    if (do_start) begin
      @(negedge clk); start_v[idx] = 1'b1;
      @(negedge clk); start_v[idx] = 1'b0;
    end
    check({tag, " busy_rise"}, 32'(busy_w[idx]),     32'd1);
    check({tag, " sk_in0"},    32'(sk_in_w[idx]),    32'd0);
    check({tag, " cnt_clr"},   32'(fail_cnt_w[idx]), 32'd0);
    check({tag, " ffv_clr"},   32'(ffv_w[idx]),      32'd0);
    prev = sk_in_w[idx];
    cyc = 0;
    while (done_w[idx] == 1'b0 && cyc < 2000) begin
      if (hold_len > 0 && cyc == hold_off) hold_v[idx] = 1'b1;
      if (hold_len > 0 && cyc == hold_off + hold_len) hold_v[idx] = 1'b0;
      if (mid_start && cyc == 100) start_v[idx] = 1'b1;
      if (mid_start && cyc == 101) start_v[idx] = 1'b0;
      @(negedge clk);
      cyc++;
      if (sk_in_w[idx] != prev) begin
        if (sk_in_w[idx] == prev + 8'd1) distinct++;
        else seq_err++;
        prev = sk_in_w[idx];
      end
    end
    hold_v[idx] = 1'b0;
    start_v[idx] = 1'b0;
    check({tag, " done_cycle"}, 32'(cyc), 32'(256 + lat + 1 + hold_len));
    check({tag, " fail_cnt"},   32'(fail_cnt_w[idx]), 32'(exp_fail));
    check({tag, " pass"},       32'(pass_w[idx]), 32'(exp_fail == 0));
    check({tag, " seq_err"},    32'(seq_err), 32'd0);
    check({tag, " distinct"},   32'(distinct), 32'd255);
    check({tag, " sk_in_last"}, 32'(sk_in_w[idx]), 32'hFF);
`ifdef SKSWEEP_FIRSTFAIL_EN
    check({tag, " ffv"}, 32'(ffv_w[idx]), 32'(exp_fail != 0));
    if (exp_fail != 0) check({tag, " ff"}, 32'(first_fail_w[idx]), 32'(exp_first));
`else
    check({tag, " ffv"}, 32'(ffv_w[idx]), 32'd0);
    check({tag, " ff"},  32'(first_fail_w[idx]), 32'd0);
`endif
    if (restart) start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    check({tag, " done_pulse"}, 32'(done_w[idx]), 32'd0);
    check({tag, " pass_after"}, 32'(pass_w[idx]), restart ? 32'd0 : 32'(exp_fail == 0));
    check({tag, " busy_after"}, 32'(busy_w[idx]), 32'(restart));
  endtask

  task automatic wait_vec(input int idx, input logic [7:0] v, input string tag);
    int n;
    n = 0;
    while (sk_in_w[idx] != v && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " reach"}, 32'(n < 1000), 32'd1);
  endtask

  task automatic abort_run(input int idx);
    int ndone;
    flip_tab = '0;
    flip_tab[8'h10] = 1'b1;
    @(negedge clk); start_v[idx] = 1'b1;
    @(negedge clk); start_v[idx] = 1'b0;
    wait_vec(idx, 8'h40, "abort");
    abort_v[idx] = 1'b1;
    @(negedge clk);
    abort_v[idx] = 1'b0;
    check("abort busy",     32'(busy_w[idx]),     32'd0);
    check("abort done",     32'(done_w[idx]),     32'd0);
    check("abort pass",     32'(pass_w[idx]),     32'd0);
    check("abort fail_cnt", 32'(fail_cnt_w[idx]), 32'd1);
`ifdef SKSWEEP_FIRSTFAIL_EN
    check("abort ffv", 32'(ffv_w[idx]),        32'd1);
    check("abort ff",  32'(first_fail_w[idx]), 32'h10);
`endif
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_w[idx]) ndone++;
    end
    check("abort no_done", 32'(ndone), 32'd0);
    check("abort idle",    32'(busy_w[idx]), 32'd0);
    flip_tab = '0;
    sweep(idx, 1'b1, 0, 0, 1'b0, 1'b0, "post_abort");
  endtask

  task automatic reset_in_drain(input int idx);
    int ndone;
    flip_tab = '0;
    flip_tab[8'h05] = 1'b1;
    @(negedge clk); start_v[idx] = 1'b1;
    @(negedge clk); start_v[idx] = 1'b0;
    wait_vec(idx, 8'hFF, "drain");
    @(negedge clk);
    check("drain busy", 32'(busy_w[idx]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset(idx, "rst_drain");
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_w[idx]) ndone++;
    end
    check("rst_drain no_done", 32'(ndone), 32'd0);
    sweep(idx, 1'b1, 0, 0, 1'b0, 1'b0, "post_rst");
  endtask

  initial begin
    rst = 1'b1;
    start_v = '0;
    abort_v = '0;
    hold_v = '0;
    flip_tab = '0;
    repeat (3) @(negedge clk);
    check_reset(0, "por0");
    check_reset(1, "por1");
    rst = 1'b0;
    @(negedge clk);

    sweep(0, 1'b1, 0, 0, 1'b0, 1'b0, "clean_l1");

    flip_tab = '0;
    flip_tab[8'h05] = 1'b1;
    flip_tab[8'hF0] = 1'b1;
    sweep(0, 1'b1, 0, 0, 1'b0, 1'b0, "two_flip");

    set_flips(3);
    sweep(1, 1'b1, 60, 10, 1'b0, 1'b0, "hold_l3");

    set_flips(1);
    sweep(1, 1'b1, 0, 0, 1'b1, 1'b1, "mid_start");
    sweep(1, 1'b0, 0, 0, 1'b0, 1'b0, "restart");

    abort_run(0);
    reset_in_drain(1);

    for (int it = 0; it < 4; it++) begin
      int idx, hl;
      idx = int'($urandom_range(0, 1));
      hl = int'($urandom_range(0, 12));
      set_flips(int'($urandom_range(0, 4)));
      sweep(idx, 1'b1, int'($urandom_range(10, 200)), hl, 1'b0, 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
